// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter: shares one single-port memory between fetch and LSU.   |
// | Optional feature macro: MEM_ARB_FLUSH_EN (adds i_if_flush).              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_if_req,
    input  logic [ADDR_W-1:0]     i_if_addr,
    output logic                  o_if_ready,
    output logic                  o_if_rvalid,
    output logic [DATA_W-1:0]     o_if_rdata,
    input  logic                  i_d_req,
    input  logic                  i_d_we,
    input  logic [ADDR_W-1:0]     i_d_addr,
    input  logic [DATA_W-1:0]     i_d_wdata,
    input  logic [DATA_W/8-1:0]   i_d_be,
    output logic                  o_d_ready,
    output logic                  o_d_rvalid,
    output logic [DATA_W-1:0]     o_d_rdata,
`ifdef MEM_ARB_FLUSH_EN
    input  logic                  i_if_flush,
`endif
    output logic                  o_mem_en,
    output logic [DATA_W/8-1:0]   o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_addr,
    output logic [DATA_W-1:0]     o_mem_wdata,
    input  logic [DATA_W-1:0]     i_mem_rdata,
    output logic                  o_busy
);

    localparam int         c_BE_W   = DATA_W / 8;
    localparam logic [2:0] c_LAT    = 3'(MEM_LAT);
    localparam logic [3:0] c_STARVE = 4'(STARVE_MAX);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_lat_cnt, w_lat_nxt;
    logic [3:0]  r_starve, w_starve_nxt;
    logic        r_owner_d, w_owner_nxt;
    logic        w_grant_d, w_grant_i;
`ifdef MEM_ARB_FLUSH_EN
    logic        r_flushed, w_flushed_nxt;
`endif

    // Data wins unless it has already starved a waiting fetch STARVE_MAX times.
    assign w_grant_d = i_d_req && (!i_if_req || (r_starve < c_STARVE));
    assign w_grant_i = !w_grant_d && i_if_req;

    assign o_if_rdata = i_mem_rdata;
    assign o_d_rdata  = i_mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_lat_cnt <= 3'd0;
            r_starve  <= 4'd0;
            r_owner_d <= 1'b0;
`ifdef MEM_ARB_FLUSH_EN
            r_flushed <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_lat_cnt <= w_lat_nxt;
            r_starve  <= w_starve_nxt;
            r_owner_d <= w_owner_nxt;
`ifdef MEM_ARB_FLUSH_EN
            r_flushed <= w_flushed_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_lat_nxt    = r_lat_cnt;
        w_starve_nxt = r_starve;
        w_owner_nxt  = r_owner_d;
`ifdef MEM_ARB_FLUSH_EN
        w_flushed_nxt = r_flushed;
`endif
        o_if_ready   = 1'b0;
        o_d_ready    = 1'b0;
        o_if_rvalid  = 1'b0;
        o_d_rvalid   = 1'b0;
        o_mem_en     = 1'b0;
        o_mem_we     = '0;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        o_busy       = 1'b0;

        case (r_state)
            ST_IDLE: begin
`ifdef MEM_ARB_FLUSH_EN
                w_flushed_nxt = 1'b0;
`endif
                if (w_grant_d) begin
                    o_d_ready    = 1'b1;
                    o_mem_en     = 1'b1;
                    o_mem_addr   = i_d_addr;
                    w_starve_nxt = i_if_req ? (r_starve + 4'd1) : 4'd0;
                    if (i_d_we) begin
                        o_mem_we    = i_d_be;
                        o_mem_wdata = i_d_wdata;
                    end else begin
                        w_state_nxt = ST_WAIT;
                        w_lat_nxt   = c_LAT;
                        w_owner_nxt = 1'b1;
                    end
                end else if (w_grant_i) begin
                    o_if_ready   = 1'b1;
                    o_mem_en     = 1'b1;
                    o_mem_addr   = i_if_addr;
                    w_starve_nxt = 4'd0;
                    w_state_nxt  = ST_WAIT;
                    w_lat_nxt    = c_LAT;
                    w_owner_nxt  = 1'b0;
                end else begin
                    w_starve_nxt = 4'd0;
                end
            end
            ST_WAIT: begin
                o_busy    = 1'b1;
                w_lat_nxt = r_lat_cnt - 3'd1;
`ifdef MEM_ARB_FLUSH_EN
                w_flushed_nxt = r_flushed | i_if_flush;
`endif
                // Counter value 1 here means it reaches zero this cycle: data is back.
                if (r_lat_cnt == 3'd1) begin
                    w_state_nxt = ST_IDLE;
                    if (r_owner_d) begin
                        o_d_rvalid = 1'b1;
                    end else begin
`ifdef MEM_ARB_FLUSH_EN
                        o_if_rvalid = !(r_flushed || i_if_flush);
`else
                        o_if_rvalid = 1'b1;
`endif
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are held quiet for the whole time reset is asserted.
        if (!rst_n) begin
            o_if_ready  = 1'b0;
            o_d_ready   = 1'b0;
            o_if_rvalid = 1'b0;
            o_d_rvalid  = 1'b0;
            o_mem_en    = 1'b0;
            o_mem_we    = '0;
            o_mem_addr  = '0;
            o_mem_wdata = '0;
            o_busy      = 1'b0;
        end
    end

    if (c_BE_W * 8 != DATA_W) begin : g_width_guard
        $error("DATA_W must be a multiple of 8");
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model and a behavioural memory.
module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [3:0]  d_be;
`ifdef MEM_ARB_FLUSH_EN
    logic        if_flush;
`endif
    logic        if_ready, if_rvalid, d_ready, d_rvalid, mem_en, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_we;

    int total = 0;
    int bad   = 0;

    logic [31:0] phys    [256];
    logic [31:0] exp_mem [256];
    logic [31:0] rd_pipe [LAT];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_ready(if_ready),
        .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata),
        .i_d_be(d_be), .o_d_ready(d_ready), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
`ifdef MEM_ARB_FLUSH_EN
        .i_if_flush(if_flush),
`endif
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata), .o_busy(busy)
    );

    // Behavioural single-port BRAM, read-first, LAT-cycle read pipeline.
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) phys[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            rd_pipe[0] <= phys[mem_addr[9:2]];
        end else begin
            rd_pipe[0] <= 32'h0BAD_F00D;
        end
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[LAT-1];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b1;
        d_addr = 32'h20; d_wdata = 32'hFFFF_FFFF; d_be = 4'hF;
        @(negedge clk);
        total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL reset_if_ready got=%b exp=0", if_ready); end
        total++; if (d_ready !== 1'b0) begin bad++; $display("FAIL reset_d_ready got=%b exp=0", d_ready); end
        total++; if (mem_en !== 1'b0 || mem_we !== 4'h0) begin bad++; $display("FAIL reset_mem_en_we got=%b/%h exp=0/0", mem_en, mem_we); end
        total++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_addr_wdata got=%h/%h exp=0/0", mem_addr, mem_wdata); end
        total++; if (busy !== 1'b0 || if_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin bad++; $display("FAIL reset_busy_rvalid got=%b%b%b exp=000", busy, if_rvalid, d_rvalid); end
        tick();
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        logic [31:0] exp;
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        total++; if (if_ready !== 1'b1 || d_ready !== 1'b0) begin bad++; $display("FAIL fetch_ready got=%b%b exp=10", if_ready, d_ready); end
        total++; if (mem_en !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 4'h0) begin bad++; $display("FAIL fetch_mem got=%b/%h/%h exp=1/100/0", mem_en, mem_addr, mem_we); end
        exp = exp_mem[8'h40];
        tick();
        if_req = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            total++; if (busy !== 1'b1 || if_ready !== 1'b0) begin bad++; $display("FAIL fetch_wait k=%0d busy/ready got=%b%b exp=10", k, busy, if_ready); end
            total++; if (if_rvalid !== (k == LAT) || d_rvalid !== 1'b0) begin bad++; $display("FAIL fetch_rvalid k=%0d got=%b%b exp=%b0", k, if_rvalid, d_rvalid, k == LAT); end
            if (k == LAT) begin
                total++; if (if_rdata !== exp) begin bad++; $display("FAIL fetch_rdata got=%h exp=%h", if_rdata, exp); end
            end
            tick();
        end
    endtask

    task automatic test_store();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
        @(negedge clk);
        total++; if (d_ready !== 1'b1 || mem_en !== 1'b1) begin bad++; $display("FAIL store_ready got=%b%b exp=11", d_ready, mem_en); end
        total++; if (mem_we !== 4'b0011 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h2000) begin bad++; $display("FAIL store_mem got=%h/%h/%h exp=3/deadbeef/2000", mem_we, mem_wdata, mem_addr); end
        exp_mem[0] = merge(exp_mem[0], 32'hDEAD_BEEF, 4'b0011);
        tick();
        d_addr = 32'h2004; d_wdata = 32'h1234_5678; d_be = 4'b0000;
        @(negedge clk);
        total++; if (d_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'h0) begin bad++; $display("FAIL store_be0 got=%b/%b/%h exp=1/1/0", d_ready, mem_en, mem_we); end
        tick();
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        total++; if (d_rvalid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL store_no_rvalid got=%b%b exp=00", d_rvalid, busy); end
        tick();
        d_req = 1'b1; d_addr = 32'h2000;
        @(negedge clk);
        tick();
        d_req = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == LAT) begin
                total++; if (d_rvalid !== 1'b1 || d_rdata !== exp_mem[0]) begin bad++; $display("FAIL store_readback got=%b/%h exp=1/%h", d_rvalid, d_rdata, exp_mem[0]); end
            end
            tick();
        end
    endtask

    task automatic test_latency();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; if_req = 1'b1; if_addr = 32'h44;
        @(negedge clk);
        total++; if (d_ready !== 1'b1 || if_ready !== 1'b0) begin bad++; $display("FAIL lat_grant got=%b%b exp=10", d_ready, if_ready); end
        tick();
        d_req = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            total++; if (if_ready !== 1'b0 || d_ready !== 1'b0 || mem_en !== 1'b0) begin bad++; $display("FAIL lat_quiet k=%0d got=%b%b%b exp=000", k, if_ready, d_ready, mem_en); end
            total++; if (d_rvalid !== (k == LAT) || if_rvalid !== 1'b0) begin bad++; $display("FAIL lat_rvalid k=%0d got=%b%b exp=%b0", k, d_rvalid, if_rvalid, k == LAT); end
            if (k == LAT) begin
                total++; if (d_rdata !== exp_mem[8'h10]) begin bad++; $display("FAIL lat_rdata got=%h exp=%h", d_rdata, exp_mem[8'h10]); end
            end
            tick();
        end
        @(negedge clk);
        total++; if (if_ready !== 1'b1 || mem_addr !== 32'h44) begin bad++; $display("FAIL lat_held_fetch got=%b/%h exp=1/44", if_ready, mem_addr); end
        tick();
        if_req = 1'b0;
        repeat (LAT) tick();
    endtask

    task automatic test_starve();
        string s;
        int    cyc;
        s = ""; cyc = 0;
        if_req = 1'b1; if_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h300; d_be = 4'hF; d_wdata = $urandom;
        while (s.len() < 10 && cyc < 80) begin
            @(negedge clk);
            if (d_ready === 1'b1) begin s = {s, "D"}; exp_mem[8'hC0] = d_wdata; end
            if (if_ready === 1'b1) s = {s, "I"};
            tick();
            d_wdata = $urandom;
            cyc++;
        end
        d_req = 1'b0; if_req = 1'b0;
        total++; if (s != "DDDDIDDDDI") begin bad++; $display("FAIL starve_order got=%s exp=DDDDIDDDDI", s); end
        repeat (LAT) tick();
        d_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            total++; if (d_ready !== 1'b1) begin bad++; $display("FAIL starve_noif k=%0d got=%b exp=1", k, d_ready); end
            exp_mem[8'hC0] = d_wdata;
            tick();
            d_wdata = $urandom;
        end
        if_req = 1'b1; s = ""; cyc = 0;
        while (s.len() < 5 && cyc < 40) begin
            @(negedge clk);
            if (d_ready === 1'b1) begin s = {s, "D"}; exp_mem[8'hC0] = d_wdata; end
            if (if_ready === 1'b1) s = {s, "I"};
            tick();
            d_wdata = $urandom;
            cyc++;
        end
        d_req = 1'b0; if_req = 1'b0; d_we = 1'b0;
        total++; if (s != "DDDDI") begin bad++; $display("FAIL starve_cleared got=%s exp=DDDDI", s); end
        repeat (LAT) tick();
    endtask

    task automatic test_reset_midread();
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
        @(negedge clk);
        total++; if (d_ready !== 1'b1) begin bad++; $display("FAIL rstmid_grant got=%b exp=1", d_ready); end
        tick();
        d_req = 1'b0; if_req = 1'b1; if_addr = 32'h48;
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || if_ready !== 1'b0 || mem_en !== 1'b0 || d_rvalid !== 1'b0) begin bad++; $display("FAIL rstmid_quiet got=%b%b%b%b exp=0000", busy, if_ready, mem_en, d_rvalid); end
        tick();
        if_req = 1'b0; rst_n = 1'b1;
        for (int k = 0; k <= LAT; k++) begin
            @(negedge clk);
            total++; if (d_rvalid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_dropped k=%0d got=%b%b exp=00", k, d_rvalid, busy); end
            tick();
        end
        if_req = 1'b1;
        @(negedge clk);
        total++; if (if_ready !== 1'b1 || mem_addr !== 32'h48) begin bad++; $display("FAIL rstmid_next got=%b/%h exp=1/48", if_ready, mem_addr); end
        tick();
        if_req = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == LAT) begin
                total++; if (if_rvalid !== 1'b1 || if_rdata !== exp_mem[8'h12]) begin bad++; $display("FAIL rstmid_rdata got=%b/%h exp=1/%h", if_rvalid, if_rdata, exp_mem[8'h12]); end
            end
            tick();
        end
    endtask

`ifdef MEM_ARB_FLUSH_EN
    task automatic test_flush();
        if_req = 1'b1; if_addr = 32'h104;
        @(negedge clk);
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL flush_grant got=%b exp=1", if_ready); end
        tick();
        if_req = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            if_flush = (k == 1);
            @(negedge clk);
            total++; if (if_rvalid !== 1'b0) begin bad++; $display("FAIL flush_suppress k=%0d got=%b exp=0", k, if_rvalid); end
            tick();
        end
        if_flush = 1'b0;
        // Flush during the grant cycle itself falls in IDLE and must not suppress.
        if_req = 1'b1; if_flush = 1'b1;
        @(negedge clk);
        tick();
        if_req = 1'b0; if_flush = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            if (k == LAT) begin
                total++; if (if_rvalid !== 1'b1) begin bad++; $display("FAIL flush_idle_noeffect got=%b exp=1", if_rvalid); end
            end
            tick();
        end
    endtask
`endif

    task automatic test_random();
        int          cyc, m_grant, m_done, m_starve;
        bit          m_pend, m_owner_d, m_flushed, idle, gd, gi;
        logic [31:0] m_data, exp_addr;
        logic [3:0]  exp_we;
        bit          exp_irv, exp_drv;
        rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0;
        tick();
        rst_n = 1'b1;
        m_pend = 0; m_owner_d = 0; m_flushed = 0; m_starve = 0; m_grant = 0; m_done = 0;
        m_data = '0;
        for (cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
`ifdef MEM_ARB_FLUSH_EN
            if (m_pend && cyc > m_grant && if_flush) m_flushed = 1;
`endif
            idle = !m_pend;
            gd = idle && d_req && (!if_req || m_starve < SMAX);
            gi = idle && !gd && if_req;
            exp_addr = gd ? d_addr : (gi ? if_addr : 32'h0);
            exp_we   = (gd && d_we) ? d_be : 4'h0;
            exp_irv  = m_pend && cyc == m_done && !m_owner_d && !m_flushed;
            exp_drv  = m_pend && cyc == m_done && m_owner_d;
            total++; if (if_ready !== gi || d_ready !== gd) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b%b exp=%b%b", cyc, if_ready, d_ready, gi, gd); end
            total++; if (mem_en !== (gd || gi) || mem_addr !== exp_addr || mem_we !== exp_we) begin bad++; $display("FAIL rand_mem cyc=%0d got=%b/%h/%h exp=%b/%h/%h", cyc, mem_en, mem_addr, mem_we, gd || gi, exp_addr, exp_we); end
            total++; if (busy !== m_pend) begin bad++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, m_pend); end
            total++; if (if_rvalid !== exp_irv || d_rvalid !== exp_drv) begin bad++; $display("FAIL rand_rvalid cyc=%0d got=%b%b exp=%b%b", cyc, if_rvalid, d_rvalid, exp_irv, exp_drv); end
            if (exp_irv) begin
                total++; if (if_rdata !== m_data) begin bad++; $display("FAIL rand_if_rdata cyc=%0d got=%h exp=%h", cyc, if_rdata, m_data); end
            end
            if (exp_drv) begin
                total++; if (d_rdata !== m_data) begin bad++; $display("FAIL rand_d_rdata cyc=%0d got=%h exp=%h", cyc, d_rdata, m_data); end
            end
            if (gd && d_we) begin
                total++; if (mem_wdata !== d_wdata) begin bad++; $display("FAIL rand_wdata cyc=%0d got=%h exp=%h", cyc, mem_wdata, d_wdata); end
            end
            if (m_pend && cyc == m_done) m_pend = 0;
            if (gd && d_we) begin
                exp_mem[d_addr[9:2]] = merge(exp_mem[d_addr[9:2]], d_wdata, d_be);
            end else if (gd || gi) begin
                m_pend = 1; m_owner_d = gd; m_grant = cyc; m_done = cyc + LAT; m_flushed = 0;
                m_data = exp_mem[exp_addr[9:2]];
            end
            if (gd && if_req) m_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
            else if (idle && (gi || !if_req)) m_starve = 0;
            tick();
            if (!if_req || gi) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = 32'($urandom_range(0, 255)) << 2;
            end
            if (!d_req || gd) begin
                d_req   = ($urandom_range(0, 1) != 0);
                d_we    = ($urandom_range(0, 1) != 0);
                d_addr  = 32'($urandom_range(0, 255)) << 2;
                d_wdata = $urandom;
                d_be    = 4'($urandom);
            end
`ifdef MEM_ARB_FLUSH_EN
            if_flush = ($urandom_range(0, 3) == 0);
`endif
        end
        if_req = 1'b0; d_req = 1'b0;
`ifdef MEM_ARB_FLUSH_EN
        if_flush = 1'b0;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            phys[i]    = (32'(i) * 32'h0101_0101) ^ 32'hA500_005A;
            exp_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA500_005A;
        end
        for (int i = 0; i < LAT; i++) rd_pipe[i] = '0;
        rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;
`ifdef MEM_ARB_FLUSH_EN
        if_flush = 1'b0;
`endif
        test_reset();
        test_fetch();
        test_store();
        test_latency();
        test_starve();
        test_reset_midread();
`ifdef MEM_ARB_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
